// File: rtl/add_pipe_seg.sv
// add_pipe_seg: pipelined ripple-segment adder.
// WIDTH bits are split into NSTG = WIDTH/SEG segments. Stage k adds segment k
// plus the carry registered by stage k-1, so the carry moves one segment per
// clock. Operand segments wait in skew registers until their stage is reached.
// Finished sum segments wait in deskew registers so that a whole result leaves
// together. Valid/ready handshake on both sides. A stalled output freezes every
// register in the pipe.
// WIDTH must be an integer multiple of SEG.
// Optional feature: define ADD_PIPE_SUB_EN to add the 'sub' input
// (sub=1 gives a - b, with cout=1 meaning no borrow).
module add_pipe_seg #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef ADD_PIPE_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSTG = WIDTH / SEG;

    // Operands after optional subtract conditioning.
    logic [WIDTH-1:0]         b_eff;
    logic                     cin_eff;

    // Handshake.
    logic                     stall;
    logic                     adv;

    // Per-stage registers: valid bit, segment carry-out, segment sum.
    logic [NSTG-1:0]          vld_q, vld_d;
    logic [NSTG-1:0]          cy_q,  cy_d;
    logic [NSTG-1:0][SEG-1:0] seg_sum_q, seg_sum_d;

    // Operand segment k as presented to stage k (already skewed).
    logic [NSTG-1:0][SEG-1:0] stg_a;
    logic [NSTG-1:0][SEG-1:0] stg_b;

    // Sum segment k after deskew, aligned with the last stage.
    logic [NSTG-1:0][SEG-1:0] out_seg;

    // Bit k feeds stage k. Bit NSTG is the output of the last stage.
    logic [NSTG:0]            v_chain;
    logic [NSTG:0]            c_chain;

    // Subtract folds into stage 0 as a + ~b + 1. Carry-in is overridden.
    always_comb begin
`ifdef ADD_PIPE_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : cin;
`else
        b_eff   = b;
        cin_eff = cin;
`endif
    end

    assign v_chain   = {vld_q, in_valid};
    assign c_chain   = {cy_q, cin_eff};

    assign out_valid = v_chain[NSTG];
    assign cout      = c_chain[NSTG];
    assign sum       = out_seg;

    // A held result blocks the whole pipe.
    // Bubbles still advance whenever there is no stall.
    assign stall     = out_valid & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = adv;

    // Per-stage segment add. Each stage is a plain (SEG+1)-bit add of its
    // operand segment and the carry from the stage before.
    always_comb begin
        logic [SEG:0] add_w;
        add_w     = '0;
        vld_d     = vld_q;
        cy_d      = cy_q;
        seg_sum_d = seg_sum_q;
        if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                add_w        = {1'b0, stg_a[k]} + {1'b0, stg_b[k]} + {{SEG{1'b0}}, c_chain[k]};
                vld_d[k]     = v_chain[k];
                cy_d[k]      = add_w[SEG];
                seg_sum_d[k] = add_w[SEG-1:0];
            end
        end
    end

    // Stage registers. Reset discards every in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            cy_q      <= '0;
            seg_sum_q <= '0;
        end else begin
            vld_q     <= vld_d;
            cy_q      <= cy_d;
            seg_sum_q <= seg_sum_d;
        end
    end

    // Segment gi: skew its operands by gi cycles and deskew its sum by
    // NSTG-1-gi cycles, so every piece of a transaction stays in step.
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_seg
        localparam int DSK = NSTG - 1 - gi;

        if (gi == 0) begin : g_skw_none
            assign stg_a[gi] = a[SEG-1:0];
            assign stg_b[gi] = b_eff[SEG-1:0];
        end else begin : g_skw
            // Entry 0 is the newest. Entry gi-1 is presented to stage gi.
            // Each entry packs {a segment, b segment}.
            logic [gi-1:0][2*SEG-1:0] skw_q, skw_d;

            // Shift the operand segment towards its stage when the pipe advances.
            always_comb begin
                skw_d = skw_q;
                if (adv) begin
                    skw_d[0] = {a[gi*SEG +: SEG], b_eff[gi*SEG +: SEG]};
                    for (int j = 1; j < gi; j++) begin
                        skw_d[j] = skw_q[j-1];
                    end
                end
            end

            // Operand skew register chain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skw_q <= '0;
                end else begin
                    skw_q <= skw_d;
                end
            end

            assign stg_a[gi] = skw_q[gi-1][2*SEG-1:SEG];
            assign stg_b[gi] = skw_q[gi-1][SEG-1:0];
        end

        if (DSK == 0) begin : g_dsk_none
            assign out_seg[gi] = seg_sum_q[gi];
        end else begin : g_dsk
            // Entry 0 is the newest. Entry DSK-1 lines up with the last stage.
            logic [DSK-1:0][SEG-1:0] dsk_q, dsk_d;

            // Carry the finished sum segment along until the top segment is done.
            always_comb begin
                dsk_d = dsk_q;
                if (adv) begin
                    dsk_d[0] = seg_sum_q[gi];
                    for (int j = 1; j < DSK; j++) begin
                        dsk_d[j] = dsk_q[j-1];
                    end
                end
            end

            // Sum deskew register chain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dsk_q <= '0;
                end else begin
                    dsk_q <= dsk_d;
                end
            end

            assign out_seg[gi] = dsk_q[DSK-1];
        end
    end

endmodule

// File: tb/tb_add_pipe_seg.sv
// Testbench for add_pipe_seg.
// Two instances run side by side: WIDTH=16/SEG=4 (4 stages) and
// WIDTH=16/SEG=16 (1 stage). Each instance gets an independent random
// valid/ready stream. A scoreboard holds expected results computed from
// a+b+cin (or a-b with borrow when built with ADD_PIPE_SUB_EN).
`timescale 1ns/1ps
module tb_add_pipe_seg;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [1:0]         in_valid_v;
    logic [1:0]         out_ready_v;
    logic [1:0]         cin_v;
    logic [1:0]         sub_v;
    logic [1:0][W-1:0]  a_v;
    logic [1:0][W-1:0]  b_v;
    wire  [1:0]         in_ready_v;
    wire  [1:0]         out_valid_v;
    wire  [1:0]         cout_v;
    wire  [1:0][W-1:0]  sum_v;

    // Hand-computed expectation attached to a directed vector.
    logic [1:0]         lit_en_v;
    logic [1:0][W:0]    lit_v;

    add_pipe_seg #(.WIDTH(16), .SEG(4)) u_dut_s4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
`ifdef ADD_PIPE_SUB_EN
        .sub       (sub_v[0]),
`endif
        .a         (a_v[0]),
        .b         (b_v[0]),
        .cin       (cin_v[0]),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .sum       (sum_v[0]),
        .cout      (cout_v[0])
    );

    add_pipe_seg #(.WIDTH(16), .SEG(16)) u_dut_s16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
`ifdef ADD_PIPE_SUB_EN
        .sub       (sub_v[1]),
`endif
        .a         (a_v[1]),
        .b         (b_v[1]),
        .cin       (cin_v[1]),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .sum       (sum_v[1]),
        .cout      (cout_v[1])
    );

    // Reference: {cout, sum} straight from the arithmetic definition.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W-1:0] diff;
        if (s) begin
            diff = x - y;
            return {(x >= y), diff};
        end
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Scoreboard: expected value and the cycle it was accepted.
    logic [W:0] sb_val [2][256];
    int         sb_t   [2][256];
    int         wr [2];
    int         rd [2];
    int         nstg [2] = '{4, 1};

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         to_cnt = 0;
    int         to_seen = 0;
    bit         nobp;
    logic [1:0]      acc_v;
    logic [1:0]      prev_stall;
    logic [1:0][W:0] prev_out;
    logic [W:0]      got;
    logic [W:0]      exp_v;
    int              head;

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (to_cnt != to_seen) begin
            errors++;
            $display("FAIL drain_timeout: results still outstanding after bound (got %0d timeouts, required 0)",
                     to_cnt - to_seen);
            to_seen = to_cnt;
        end
        for (int d = 0; d < 2; d++) begin
            got = {cout_v[d], sum_v[d]};
            if (!rst_n) begin
                checks++;
                if (out_valid_v[d] !== 1'b0 || sum_v[d] !== '0 || cout_v[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state dut%0d: got out_valid=%b sum=%h cout=%b, required 0 0000 0",
                             d, out_valid_v[d], sum_v[d], cout_v[d]);
                end
                rd[d]         = wr[d];
                acc_v[d]      = 1'b0;
                prev_stall[d] = 1'b0;
                prev_out[d]   = got;
            end else begin
                checks++;
                if (in_ready_v[d] !== ~(out_valid_v[d] & ~out_ready_v[d])) begin
                    errors++;
                    $display("FAIL in_ready dut%0d: got %b, required %b (out_valid=%b out_ready=%b)",
                             d, in_ready_v[d], ~(out_valid_v[d] & ~out_ready_v[d]),
                             out_valid_v[d], out_ready_v[d]);
                end
                if (prev_stall[d]) begin
                    checks++;
                    if (out_valid_v[d] !== 1'b1 || got !== prev_out[d]) begin
                        errors++;
                        $display("FAIL stall_hold dut%0d: got valid=%b {cout,sum}=%h, required 1 %h",
                                 d, out_valid_v[d], got, prev_out[d]);
                    end
                end
                head = rd[d] % 256;
                if (out_valid_v[d] === 1'b1) begin
                    checks++;
                    if (rd[d] == wr[d]) begin
                        errors++;
                        $display("FAIL spurious_output dut%0d: got {cout,sum}=%h with nothing outstanding, required out_valid=0",
                                 d, got);
                    end else begin
                        if (got !== sb_val[d][head]) begin
                            errors++;
                            $display("FAIL result dut%0d txn %0d: got {cout,sum}=%h, required %h",
                                     d, rd[d], got, sb_val[d][head]);
                        end
                        if (nobp) begin
                            checks++;
                            if (cyc - sb_t[d][head] != nstg[d]) begin
                                errors++;
                                $display("FAIL latency dut%0d txn %0d: got %0d cycles, required %0d",
                                         d, rd[d], cyc - sb_t[d][head], nstg[d]);
                            end
                        end
                        if (out_ready_v[d]) begin
                            $display("dut%0d txn %0d: sum=%h cout=%b", d, rd[d], sum_v[d], cout_v[d]);
                            rd[d]++;
                        end
                    end
                end else if (nobp && rd[d] != wr[d] && cyc - sb_t[d][head] >= nstg[d]) begin
                    checks++;
                    errors++;
                    $display("FAIL latency dut%0d txn %0d: got no output after %0d cycles, required output at %0d",
                             d, rd[d], cyc - sb_t[d][head], nstg[d]);
                end
                if (in_valid_v[d] && in_ready_v[d]) begin
                    exp_v = model(a_v[d], b_v[d], cin_v[d], sub_v[d]);
                    if (lit_en_v[d]) begin
                        checks++;
                        if (exp_v !== lit_v[d]) begin
                            errors++;
                            $display("FAIL model_pin dut%0d: got model %h, required %h", d, exp_v, lit_v[d]);
                        end
                    end
                    sb_val[d][wr[d] % 256] = exp_v;
                    sb_t[d][wr[d] % 256]   = cyc;
                    wr[d]++;
                end
                acc_v[d]      = in_valid_v[d] & in_ready_v[d];
                prev_stall[d] = out_valid_v[d] & ~out_ready_v[d];
                prev_out[d]   = got;
            end
        end
    end

    task automatic gen_vec(input int d);
        int sel;
        sel      = $urandom_range(0, 9);
        a_v[d]   = (sel == 0) ? 16'hFFFF : 16'($urandom);
        b_v[d]   = (sel == 1) ? 16'h0001 : ((sel == 2) ? 16'hFFFF : 16'($urandom));
        cin_v[d] = 1'($urandom);
`ifdef ADD_PIPE_SUB_EN
        sub_v[d] = 1'($urandom);
`else
        sub_v[d] = 1'b0;
`endif
        lit_en_v[d] = 1'b0;
    endtask

    // One clock of stimulus. A presented vector is held until accepted.
    task automatic step(input int p_valid, input int p_ready);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (acc_v[d] || !in_valid_v[d]) begin
                if ($urandom_range(0, 99) < p_valid) begin
                    in_valid_v[d] = 1'b1;
                    gen_vec(d);
                end else begin
                    in_valid_v[d] = 1'b0;
                    lit_en_v[d]   = 1'b0;
                end
            end
            out_ready_v[d] = ($urandom_range(0, 99) < p_ready);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((in_valid_v != 2'b00 || wr[0] != rd[0] || wr[1] != rd[1]) && n < 200) begin
            step(0, 100);
            n++;
        end
        if (n >= 200) to_cnt++;
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input logic s, input logic [W:0] lit);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d]  = 1'b1;
            a_v[d]         = x;
            b_v[d]         = y;
            cin_v[d]       = c;
            sub_v[d]       = s;
            lit_en_v[d]    = 1'b1;
            lit_v[d]       = lit;
            out_ready_v[d] = 1'b1;
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid_v  = 2'b11;
        out_ready_v = 2'b11;
        lit_en_v    = 2'b11;
        nobp        = 1'b1;
        wr          = '{0, 0};
        rd          = '{0, 0};
        for (int d = 0; d < 2; d++) begin
            a_v[d]   = 16'h1234;
            b_v[d]   = 16'h4321;
            cin_v[d] = 1'b1;
            sub_v[d] = 1'b0;
            lit_v[d] = 17'h0_5556;
        end

        // Reset held with a valid input pending, then release.
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        drain();

        // Directed vectors with hand-computed results.
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000);
        directed(16'h1234, 16'h4321, 1'b1, 1'b0, 17'h0_5556);
        directed(16'h0FFF, 16'h0001, 1'b0, 1'b0, 17'h0_1000);
        directed(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1_FFFF);
        directed(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h1_0000);
        directed(16'h0000, 16'h0000, 1'b0, 1'b0, 17'h0_0000);
`ifdef ADD_PIPE_SUB_EN
        directed(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE);
        directed(16'h0007, 16'h0005, 1'b1, 1'b1, 17'h1_0002);
`endif

        // Back-to-back stream, no backpressure.
        repeat (100) step(100, 100);
        drain();

        // Random backpressure.
        nobp = 1'b0;
        repeat (400) step(80, 50);
        drain();
        nobp = 1'b1;

        // Reset with transactions in flight.
        repeat (4) step(100, 100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        in_valid_v = 2'b00;
        lit_en_v   = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) step(0, 100);

        // Traffic after the mid-flight reset.
        nobp = 1'b0;
        repeat (200) step(70, 60);
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
